mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It latches the execute-to-memory bus under the shared stall vector and extracts and sign/zero-extends load data from the synchronous data SRAM. It selects the writeback value and drives the writeback bus plus the forwarding bus back to decode. A hold register keeps load data correct while the stage is stalled after the SRAM read cycle.

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_stage_load_align.sv | 38 +++
 rtl/mem_stage.sv | 73 +++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load opcodes and bus layout for the memory stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_MEM_BIT = 3;
  localparam int STALL_WB_BIT  = 4;

  typedef enum logic [2:0] {
    MEM_OP_LW  = 3'b000,
    MEM_OP_LB  = 3'b001,
    MEM_OP_LBU = 3'b010,
    MEM_OP_LH  = 3'b011,
    MEM_OP_LHU = 3'b100
  } mem_op_e;

  typedef enum logic {
    RD_FRESH = 1'b0,
    RD_HELD  = 1'b1
  } rd_state_e;

  // Field order matches the execute-to-memory bus, pc in the top bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  mem_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t e);
    return e.sel_rf_res & e.data_ram_en & ~(|e.data_ram_wen);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/halfword from a little-endian word and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'b00: byte_sel = raw[7:0];
      2'b01: byte_sel = raw[15:8];
      2'b10: byte_sel = raw[23:16];
      2'b11: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Unknown opcodes fall through to a full word.
  always_comb begin
    data = raw;
    case (mem_op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'b0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'b0, half_sel};
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: input register, load-data hold FSM, writeback and forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_is_load
);

  ex_to_mem_t ex_r;
  rd_state_e  rd_state;
  logic [31:0] rdata_hold;

  logic        stop_here;
  logic        bubble;
  logic [31:0] raw_word;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  assign stop_here = (stall[STALL_MEM_BIT] == STOP);
  assign bubble    = stop_here && (stall[STALL_WB_BIT] == NO_STOP);

  // SRAM data is only valid in the first resident cycle, so it is captured
  // on the first held edge and replayed for the rest of the stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_r       <= '0;
      rd_state   <= RD_FRESH;
      rdata_hold <= 32'b0;
    end else if (bubble) begin
      ex_r     <= '0;
      rd_state <= RD_FRESH;
    end else if (!stop_here) begin
      ex_r     <= ex_to_mem_t'(ex_to_mem_bus);
      rd_state <= RD_FRESH;
    end else if (rd_state == RD_FRESH) begin
      rd_state   <= RD_HELD;
      rdata_hold <= data_sram_rdata;
    end
  end

  assign raw_word = (rd_state == RD_HELD) ? rdata_hold : data_sram_rdata;

  load_align u_load_align (
    .mem_op (ex_r.mem_op),
    .addr   (ex_r.ex_result[1:0]),
    .raw    (raw_word),
    .data   (load_data)
  );

  assign rf_wdata = ex_r.sel_rf_res ? load_data : ex_r.ex_result;

  // Outputs are forced quiet while reset is held, before the register clears.
  always_comb begin
    mem_to_wb_bus = '0;
    mem_to_id_bus = '0;
    mem_is_load   = 1'b0;
    if (rst) begin
      mem_to_wb_bus = {ex_r.pc, ex_r.rf_we, ex_r.rf_waddr, rf_wdata};
      mem_to_id_bus = {ex_r.rf_we, ex_r.rf_waddr, rf_wdata};
      mem_is_load   = is_load(ex_r);
    end
  end

endmodule
